ldpc_layer_vnu_6: RTL and testbench

Upstream companion stage to the degree-6 check-node unit in the layered min-sum decoder. For one layer row, it takes six APP (a-posteriori) values and subtracts that row's previously stored check-to-variable messages, producing the six 4-bit sign-magnitude variable-to-check messages the CNU consumes. After the CNU's fixed latency, it captures the fresh check-to-variable messages, writes them back to its per-row message store, and returns the updated APP values to the APP memory controller.

---
 rtl/ldpc_layer_vnu_6.sv | 193 +++++++++++++++++++
 tb/tb_ldpc_layer_vnu_6.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_layer_vnu_6.sv
// ldpc_layer_vnu_6: variable-node stage of the layered min-sum decoder for
// degree-6 check rows. It forms v2c = APP - c2v_old for the CNU, then after
// the CNU latency folds the fresh c2v back into APP and stores it per row.
// Build option: define C2V_INPUT_REG_EN to add a register stage on c2v_in.
module ldpc_layer_vnu_6 #(
  parameter int CN_DEGREE = 6,
  parameter int QUAN_SIZE = 4,
  parameter int APP_SIZE  = 6,
  parameter int ROW_NUM   = 8,
  parameter int ROW_W     = 3,
  parameter int CNU_LAT   = 3
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ROW_W-1:0]               row,
  input  logic [CN_DEGREE*APP_SIZE-1:0]  app_in,
  output logic                           busy,
  output logic [CN_DEGREE*QUAN_SIZE-1:0] v2c_out,
  input  logic [CN_DEGREE*QUAN_SIZE-1:0] c2v_in,
  output logic [CN_DEGREE*APP_SIZE-1:0]  app_out,
  output logic                           done
);

  localparam int D_W   = APP_SIZE + 1;
  localparam int MSG_W = CN_DEGREE * QUAN_SIZE;
  localparam int APW   = CN_DEGREE * APP_SIZE;
  localparam int CNT_W = $clog2(CNU_LAT + 1);
`ifdef C2V_INPUT_REG_EN
  localparam int CNT_LAST = CNU_LAT;
`else
  localparam int CNT_LAST = CNU_LAT - 1;
`endif
  localparam logic signed [D_W-1:0] MSG_MAX = D_W'(2**(QUAN_SIZE-1) - 1);
  localparam logic signed [D_W-1:0] MSG_MIN = -MSG_MAX;
  localparam logic signed [D_W-1:0] APP_MAX = D_W'(2**(APP_SIZE-1) - 1);
  localparam logic signed [D_W-1:0] APP_MIN = -APP_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_V2C  = 2'd1,
    ST_WAIT = 2'd2,
    ST_UPD  = 2'd3
  } state_t;

  // Sign-magnitude message to two's complement; negative zero maps to 0.
  function automatic logic signed [D_W-1:0] sm_to_tc(input logic [QUAN_SIZE-1:0] sm);
    logic signed [D_W-1:0] mag;
    mag = $signed({{(D_W-QUAN_SIZE+1){1'b0}}, sm[QUAN_SIZE-2:0]});
    sm_to_tc = sm[QUAN_SIZE-1] ? -mag : mag;
  endfunction

  // Saturate to the message range and encode; zero always comes out positive.
  function automatic logic [QUAN_SIZE-1:0] sat_to_sm(input logic signed [D_W-1:0] d);
    logic [D_W-1:0] mag;
    mag = d[D_W-1] ? -d : d;
    if ((d > MSG_MAX) || (d < MSG_MIN)) begin
      sat_to_sm = {d[D_W-1], {(QUAN_SIZE-1){1'b1}}};
    end else begin
      sat_to_sm = {d[D_W-1], mag[QUAN_SIZE-2:0]};
    end
  endfunction

  // Symmetric APP saturation (the most negative code is never produced).
  function automatic logic [APP_SIZE-1:0] sat_app(input logic signed [D_W-1:0] s);
    if (s > APP_MAX) begin
      sat_app = APP_MAX[APP_SIZE-1:0];
    end else if (s < APP_MIN) begin
      sat_app = APP_MIN[APP_SIZE-1:0];
    end else begin
      sat_app = s[APP_SIZE-1:0];
    end
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      wait_cnt_r;
  logic                  accept_s, capture_s, row_ok_s;
  logic [ROW_W-1:0]      row_r;
  logic [MSG_W-1:0]      c2v_mem_r [ROW_NUM];
  logic [MSG_W-1:0]      c2v_rd_s, v2c_s, c2v_cap_s, c2v_new_r;
  logic signed [D_W-1:0] d_s [CN_DEGREE];
  logic signed [D_W-1:0] d_r [CN_DEGREE];
  logic [APW-1:0]        app_upd_s;

  generate
    if (ROW_NUM >= (1 << ROW_W)) begin : g_row_full
      assign row_ok_s = 1'b1;
    end else begin : g_row_part
      assign row_ok_s = (row < ROW_W'(ROW_NUM));
    end
  endgenerate

`ifdef C2V_INPUT_REG_EN
  logic [MSG_W-1:0] c2v_in_r;
  // Free-running input register on the CNU return path.
  always_ff @(posedge sys_clk) begin
    if (!rstn) c2v_in_r <= {MSG_W{1'b0}};
    else       c2v_in_r <= c2v_in;
  end
  assign c2v_cap_s = c2v_in_r;
`else
  assign c2v_cap_s = c2v_in;
`endif

  // Per-lane difference APP - c2v_old for the row being requested.
  always_comb begin
    v2c_s    = {MSG_W{1'b0}};
    c2v_rd_s = c2v_mem_r[row];
    for (int k = 0; k < CN_DEGREE; k++) begin
      d_s[k] = $signed({app_in[k*APP_SIZE+APP_SIZE-1], app_in[k*APP_SIZE +: APP_SIZE]})
               - sm_to_tc(c2v_rd_s[k*QUAN_SIZE +: QUAN_SIZE]);
      v2c_s[k*QUAN_SIZE +: QUAN_SIZE] = sat_to_sm(d_s[k]);
    end
  end

  // Updated APP from the unsaturated difference plus the returning c2v.
  always_comb begin
    app_upd_s = {APW{1'b0}};
    for (int k = 0; k < CN_DEGREE; k++) begin
      app_upd_s[k*APP_SIZE +: APP_SIZE] =
        sat_app(d_r[k] + sm_to_tc(c2v_cap_s[k*QUAN_SIZE +: QUAN_SIZE]));
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; wait_cnt spans the CNU latency window starting at V2C.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && row_ok_s) begin
          state_s  = ST_V2C;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_V2C, ST_WAIT: begin
        if (wait_cnt_r == CNT_W'(CNT_LAST)) begin
          state_s   = ST_UPD;
          capture_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_UPD:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Latency counter, cleared outside the V2C/WAIT window.
  always_ff @(posedge sys_clk) begin
    if (!rstn)                                         wait_cnt_r <= {CNT_W{1'b0}};
    else if (capture_s)                                wait_cnt_r <= {CNT_W{1'b0}};
    else if ((state_r == ST_V2C) || (state_r == ST_WAIT)) wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    else                                               wait_cnt_r <= {CNT_W{1'b0}};
  end

  // Datapath registers, registered outputs and the per-row c2v store.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      v2c_out   <= {MSG_W{1'b0}};
      app_out   <= {APW{1'b0}};
      row_r     <= {ROW_W{1'b0}};
      c2v_new_r <= {MSG_W{1'b0}};
      for (int k = 0; k < CN_DEGREE; k++) d_r[k] <= {D_W{1'b0}};
      for (int i = 0; i < ROW_NUM; i++) c2v_mem_r[i] <= {MSG_W{1'b0}};
    end else begin
      busy <= (state_s != ST_IDLE);
      done <= capture_s;
      if (accept_s) begin
        row_r   <= row;
        v2c_out <= v2c_s;
        for (int k = 0; k < CN_DEGREE; k++) d_r[k] <= d_s[k];
      end
      if (capture_s) begin
        c2v_new_r <= c2v_cap_s;
        app_out   <= app_upd_s;
      end
      if (state_r == ST_UPD) c2v_mem_r[row_r] <= c2v_new_r;
    end
  end

endmodule

// File: tb/tb_ldpc_layer_vnu_6.sv
// Bench for ldpc_layer_vnu_6: table of hand-derived vectors, hand sequences
// for busy/out-of-range starts and mid-flight reset, and randomized rows
// against an integer reference model of the APP/c2v arithmetic.
`timescale 1ns/1ps
module tb_ldpc_layer_vnu_6;
  localparam int LANES = 6;
  localparam int Q     = 4;
  localparam int A     = 6;
  localparam int RN    = 8;
  localparam int RW    = 3;
  localparam int LAT   = 3;
  localparam int MW    = LANES * Q;
  localparam int AW    = LANES * A;
`ifdef C2V_INPUT_REG_EN
  localparam int DONE_CYC = LAT + 2;
`else
  localparam int DONE_CYC = LAT + 1;
`endif

  typedef int         lane_int_t [LANES];
  typedef logic [3:0] lane_msg_t [LANES];
  typedef struct { int row; int app; logic [3:0] c2v; logic [3:0] v2c; int app_o; } vec_t;

  logic sys_clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [RW-1:0] row = 3'd0;
  logic [AW-1:0] app_in = {AW{1'b0}}, app_out;
  logic [MW-1:0] v2c_out, c2v_in = {MW{1'b0}};
  logic busy, done;
  logic start6 = 1'b0;
  logic [RW-1:0] row6 = 3'd0;
  logic [AW-1:0] app6 = {AW{1'b0}}, app_out6;
  logic [MW-1:0] v2c6;
  logic busy6, done6;

  int n_pass = 0, n_total = 0;
  int mem_m [RN][LANES];

  always #5 sys_clk = ~sys_clk;

  ldpc_layer_vnu_6 u_dut (
    .sys_clk(sys_clk), .rstn(rstn), .start(start), .row(row), .app_in(app_in),
    .busy(busy), .v2c_out(v2c_out), .c2v_in(c2v_in), .app_out(app_out), .done(done));

  ldpc_layer_vnu_6 #(.ROW_NUM(6)) u_dut_r6 (
    .sys_clk(sys_clk), .rstn(rstn), .start(start6), .row(row6), .app_in(app6),
    .busy(busy6), .v2c_out(v2c6), .c2v_in(c2v_in), .app_out(app_out6), .done(done6));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sm_val(input logic [3:0] c);
    int m;
    m = int'(c[2:0]);
    return c[3] ? -m : m;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [3:0] to_sm(input int v);
    return (v < 0) ? {1'b1, 3'(-v)} : {1'b0, 3'(v)};
  endfunction

  function automatic logic [AW-1:0] pack_app(input lane_int_t v);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    for (int k = 0; k < LANES; k++) r[k*A +: A] = A'(v[k]);
    return r;
  endfunction

  function automatic logic [MW-1:0] pack_msg(input lane_msg_t c);
    logic [MW-1:0] r;
    r = {MW{1'b0}};
    for (int k = 0; k < LANES; k++) r[k*Q +: Q] = c[k];
    return r;
  endfunction

  // Reference: v2c = sat7(app - old); app' = sat31(app - old + new); store new.
  task automatic model_run(input int r, input lane_int_t app, input lane_msg_t c2v,
                           output lane_msg_t ev, output lane_int_t ea);
    int d;
    for (int k = 0; k < LANES; k++) begin
      d      = app[k] - mem_m[r][k];
      ev[k]  = to_sm(clamp(d, -7, 7));
      ea[k]  = clamp(d + sm_val(c2v[k]), -31, 31);
      mem_m[r][k] = sm_val(c2v[k]);
    end
  endtask

  // One row transaction starting at a negedge; returns at the negedge after done.
  task automatic run_row(input int r, input lane_int_t app, input lane_msg_t c2v,
                         input lane_msg_t ev_l, input lane_int_t ea_l,
                         input bit inj, input string tag);
    logic [MW-1:0] ev;
    logic [AW-1:0] ea;
    int first_done, done_cnt;
    ev = pack_msg(ev_l);
    ea = pack_app(ea_l);
    first_done = -1;
    done_cnt = 0;
    start = 1'b1; row = RW'(r); app_in = pack_app(app); c2v_in = MW'($urandom);
    @(negedge sys_clk);
    start = 1'b0; app_in = AW'({$urandom, $urandom});
    check({tag, "_v2c"}, 64'(v2c_out), 64'(ev));
    check({tag, "_busy_v2c"}, 64'(busy), 64'd1);
    for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
      c2v_in = (cyc == LAT) ? pack_msg(c2v) : MW'($urandom);
      start  = inj && ((cyc == 2) || (cyc == DONE_CYC));
      row    = 3'd3;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == DONE_CYC) begin
        check({tag, "_app_out"}, 64'(app_out), 64'(ea));
        check({tag, "_v2c_held"}, 64'(v2c_out), 64'(ev));
        check({tag, "_busy_upd"}, 64'(busy), 64'd1);
      end
      if (cyc == DONE_CYC + 1) begin
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_app_held"}, 64'(app_out), 64'(ea));
      end
      if (cyc <= DONE_CYC) @(negedge sys_clk);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 64'(first_done), 64'(DONE_CYC));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    vec_t tbl [8];
    lane_int_t la, ea, ma;
    lane_msg_t lc, ev, mv;
    int cnt, r;

    tbl[0] = '{0,   5, 4'b1110, 4'b0101,  -1};
    tbl[1] = '{0,   5, 4'b0010, 4'b0111,  13};
    tbl[2] = '{1, -31, 4'b1111, 4'b1111, -31};
    tbl[3] = '{2,   0, 4'b1000, 4'b0000,   0};
    tbl[4] = '{2,   0, 4'b0000, 4'b0000,   0};
    tbl[5] = '{2,   0, 4'b0101, 4'b0000,   5};
    tbl[6] = '{3,  31, 4'b0111, 4'b0111,  31};
    tbl[7] = '{3,  -2, 4'b1001, 4'b1111, -10};
    for (int i = 0; i < RN; i++) for (int k = 0; k < LANES; k++) mem_m[i][k] = 0;

    repeat (3) @(negedge sys_clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_v2c", 64'(v2c_out), 64'd0);
    check("rst_app", 64'(app_out), 64'd0);
    rstn = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < LANES; k++) begin
        la[k] = tbl[i].app; lc[k] = tbl[i].c2v; ev[k] = tbl[i].v2c; ea[k] = tbl[i].app_o;
      end
      model_run(tbl[i].row, la, lc, mv, ma);
      run_row(tbl[i].row, la, lc, ev, ea, 1'b0, $sformatf("tbl%0d", i));
    end

    // starts during V2C/WAIT and during UPD must be dropped
    for (int k = 0; k < LANES; k++) begin la[k] = 4 - k; lc[k] = 4'(k); end
    model_run(0, la, lc, ev, ea);
    run_row(0, la, lc, ev, ea, 1'b1, "busy_start");
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) cnt++;
      @(negedge sys_clk);
    end
    check("busy_start_ignored", 64'(cnt), 64'd0);

    // out-of-range rows on a ROW_NUM=6 instance
    for (int bad = 6; bad < 8; bad++) begin
      row6 = RW'(bad); start6 = 1'b1;
      @(negedge sys_clk);
      start6 = 1'b0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
        if (busy6 || done6) cnt++;
        @(negedge sys_clk);
      end
      check($sformatf("row%0d_ignored", bad), 64'(cnt), 64'd0);
    end
    for (int k = 0; k < LANES; k++) la[k] = 5;
    row6 = 3'd5; app6 = pack_app(la); start6 = 1'b1;
    @(negedge sys_clk);
    start6 = 1'b0;
    check("r6_row5_busy", 64'(busy6), 64'd1);
    check("r6_row5_v2c", 64'(v2c6), 64'(24'h555555));
    repeat (6) @(negedge sys_clk);

    // randomized rows against the reference model
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, RN - 1);
      for (int k = 0; k < LANES; k++) begin
        la[k] = int'($urandom_range(0, 62)) - 31;
        lc[k] = 4'($urandom_range(0, 15));
      end
      model_run(r, la, lc, ev, ea);
      run_row(r, la, lc, ev, ea, 1'b0, $sformatf("rnd%0d_r%0d", n, r));
    end

    // reset two cycles into a row-0 pass clears everything
    for (int k = 0; k < LANES; k++) begin la[k] = 5; lc[k] = 4'b0011; end
    model_run(0, la, lc, ev, ea);
    run_row(0, la, lc, ev, ea, 1'b0, "pre_rst");
    start = 1'b1; row = 3'd0; app_in = pack_app(la);
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    rstn = 1'b0;
    @(negedge sys_clk);
    rstn = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_v2c", 64'(v2c_out), 64'd0);
    check("midrst_app", 64'(app_out), 64'd0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy) cnt++;
      @(negedge sys_clk);
    end
    check("midrst_quiet", 64'(cnt), 64'd0);
    for (int i = 0; i < RN; i++) for (int k = 0; k < LANES; k++) mem_m[i][k] = 0;
    for (int k = 0; k < LANES; k++) lc[k] = 4'b0001;
    model_run(0, la, lc, ev, ea);
    run_row(0, la, lc, ev, ea, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
